// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between
// the fetch port (0) and the load/store port (1), one access in flight.
module data_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int WORD_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WORD_W-1:0] wdata0,
    input  logic [WORD_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [WORD_W-1:0] rdata0,
    output logic [WORD_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       sel;
    logic       last;
    logic       we_q;
    logic [2:0] cnt;
    logic       elig0;
    logic       elig1;
    logic       any_req;
    logic       win1;
    logic       arb;
    logic       rd_cap;

    // The port finishing in DONE is masked so a held req cannot re-win.
    always_comb begin
        elig0   = req0 && !(state == DONE && !sel);
        elig1   = req1 && !(state == DONE && sel);
        any_req = elig0 || elig1;
        win1    = elig1 && (!elig0 || !last);
        arb     = (state == IDLE || state == DONE) && any_req;
        rd_cap  = state == WAIT && cnt == 3'd0 && !we_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == 3'd0) state_nxt = DONE;
            DONE:    state_nxt = any_req ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en = state == ISSUE;
        mem_we = mem_en && we_q;
        gnt0   = mem_en && !sel;
        gnt1   = mem_en && sel;
        done0  = state == DONE && !sel;
        done1  = state == DONE && sel;
        busy   = state != IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel       <= 1'b0;
            last      <= 1'b1;
            we_q      <= 1'b0;
            cnt       <= 3'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            if (arb) begin
                sel       <= win1;
                last      <= win1;
                we_q      <= win1 ? we1 : we0;
                mem_addr  <= win1 ? addr1 : addr0;
                mem_wdata <= win1 ? wdata1 : wdata0;
            end
            if (state == ISSUE) begin
                cnt <= 3'(MEM_LAT - 1);
            end else if (state == WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (rd_cap && !sel) rdata0 <= mem_rdata;
            if (rd_cap && sel)  rdata1 <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: instance 0 at MEM_LAT=1, instance 1 at
// MEM_LAT=3, each with its own memory and transaction-level model.
module tb_data_mem_arbiter;

    logic clk;
    logic reset;

    logic        req0_s[2], req1_s[2], we0_s[2], we1_s[2];
    logic [15:0] addr0_s[2], addr1_s[2], wdata0_s[2], wdata1_s[2];
    logic        gnt0_s[2], gnt1_s[2], done0_s[2], done1_s[2];
    logic [15:0] rdata0_s[2], rdata1_s[2];
    logic        mem_en_s[2], mem_we_s[2], busy_s[2];
    logic [15:0] mem_addr_s[2], mem_wdata_s[2], mem_rdata_s[2];

    int n_total = 0;
    int n_pass  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int L = (g == 0) ? 1 : 3;

        data_mem_arbiter #(.ADDR_W(16), .WORD_W(16), .MEM_LAT(L)) dut (
            .clk(clk), .reset(reset),
            .req0(req0_s[g]), .req1(req1_s[g]),
            .we0(we0_s[g]), .we1(we1_s[g]),
            .addr0(addr0_s[g]), .addr1(addr1_s[g]),
            .wdata0(wdata0_s[g]), .wdata1(wdata1_s[g]),
            .gnt0(gnt0_s[g]), .gnt1(gnt1_s[g]),
            .done0(done0_s[g]), .done1(done1_s[g]),
            .rdata0(rdata0_s[g]), .rdata1(rdata1_s[g]),
            .mem_en(mem_en_s[g]), .mem_we(mem_we_s[g]),
            .mem_addr(mem_addr_s[g]), .mem_wdata(mem_wdata_s[g]),
            .mem_rdata(mem_rdata_s[g]), .busy(busy_s[g])
        );

        // Memory with an L-stage read pipeline; junk when not reading.
        logic [15:0] mem[logic [15:0]];
        logic [15:0] pipe[3];
        initial begin
            mem[16'h0010] = 16'hBEEF;
            for (int i = 0; i < 3; i++) pipe[i] = 16'h0;
        end
        always @(posedge clk) begin
            for (int i = 2; i > 0; i--) pipe[i] <= pipe[i-1];
            if (mem_en_s[g] && !mem_we_s[g])
                pipe[0] <= mem.exists(mem_addr_s[g]) ? mem[mem_addr_s[g]]
                                                     : (mem_addr_s[g] ^ 16'h5A5A);
            else
                pipe[0] <= 16'($urandom);
            if (mem_en_s[g] && mem_we_s[g]) mem[mem_addr_s[g]] = mem_wdata_s[g];
        end
        assign mem_rdata_s[g] = pipe[L-1];

        // Model: a transaction lives L+2 cycles (age 0 issue, age L+1 done).
        logic [15:0] ref_mem[logic [15:0]];
        bit          act = 0, mp = 0, mwe = 0, mlast = 1;
        bit          fin, e0, e1, w;
        int          age = 0;
        logic [15:0] maddr = 0, mwdata = 0, mrv = 0;
        logic [15:0] mrd[2];
        initial begin
            ref_mem[16'h0010] = 16'hBEEF;
            mrd[0] = 0;
            mrd[1] = 0;
        end

        always @(posedge clk or negedge reset) begin
            if (!reset) begin
                act = 0; age = 0; mp = 0; mwe = 0; mlast = 1;
                maddr = 0; mwdata = 0; mrd[0] = 0; mrd[1] = 0;
            end else begin
                fin = act && age == L + 1;
                if (act && !fin) begin
                    age++;
                    if (age == L + 1 && !mwe) mrd[mp] = mrv;
                end else begin
                    e0  = req0_s[g] && !(fin && !mp);
                    e1  = req1_s[g] && !(fin && mp);
                    act = e0 || e1;
                    if (act) begin
                        w      = (e0 && e1) ? !mlast : e1;
                        mp     = w;
                        mlast  = w;
                        age    = 0;
                        mwe    = w ? we1_s[g] : we0_s[g];
                        maddr  = w ? addr1_s[g] : addr0_s[g];
                        mwdata = w ? wdata1_s[g] : wdata0_s[g];
                        if (mwe) ref_mem[maddr] = mwdata;
                        else mrv = ref_mem.exists(maddr) ? ref_mem[maddr]
                                                         : (maddr ^ 16'h5A5A);
                    end
                end
            end
        end

        logic [70:0] exp_v, act_v;
        always @(negedge clk) begin
            exp_v = {act && age == 0 && !mp, act && age == 0 && mp,
                     act && age == L + 1 && !mp, act && age == L + 1 && mp,
                     act && age == 0, act && age == 0 && mwe, act,
                     mrd[0], mrd[1], maddr, mwdata};
            act_v = {gnt0_s[g], gnt1_s[g], done0_s[g], done1_s[g],
                     mem_en_s[g], mem_we_s[g], busy_s[g],
                     rdata0_s[g], rdata1_s[g], mem_addr_s[g], mem_wdata_s[g]};
            n_total++;
            if (act_v === exp_v) n_pass++;
            else $display("FAIL model_inst%0d t=%0t: got %h expected %h",
                          g, $time, act_v, exp_v);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int k, int p, bit v, bit we,
                           logic [15:0] a, logic [15:0] d);
        if (p == 0) begin
            req0_s[k] = v; we0_s[k] = we; addr0_s[k] = a; wdata0_s[k] = d;
        end else begin
            req1_s[k] = v; we1_s[k] = we; addr1_s[k] = a; wdata1_s[k] = d;
        end
    endtask

    // Both ports request at once; each drops req the cycle after its done.
    task automatic run_pair(int k, bit w0, logic [15:0] a0, logic [15:0] d0,
                            bit w1, logic [15:0] a1, logic [15:0] d1);
        bit pend0 = 1, pend1 = 1, drop0 = 0, drop1 = 0;
        int n = 0;
        set_req(k, 0, 1, w0, a0, d0);
        set_req(k, 1, 1, w1, a1, d1);
        while ((pend0 || pend1) && n < 40) begin
            tick();
            n++;
            if (drop0) begin req0_s[k] = 0; drop0 = 0; end
            if (drop1) begin req1_s[k] = 0; drop1 = 0; end
            if (pend0 && done0_s[k]) begin pend0 = 0; drop0 = 1; end
            if (pend1 && done1_s[k]) begin pend1 = 0; drop1 = 1; end
        end
        tick();
        if (drop0) req0_s[k] = 0;
        if (drop1) req1_s[k] = 0;
        chk("pair_completes", n < 40, 1);
    endtask

    initial begin
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_req(k, 0, 0, 0, 0, 0);
            set_req(k, 1, 0, 0, 0, 0);
        end
        repeat (3) tick();
        chk("rst_busy", busy_s[0], 0);
        chk("rst_mem_en", mem_en_s[0], 0);
        chk("rst_mem_addr", mem_addr_s[0], 0);
        chk("rst_rdata0", rdata0_s[0], 0);
        reset = 1'b1;
        tick();

        // Read at MEM_LAT=1
        set_req(0, 0, 1, 0, 16'h0010, 0);
        tick();
        chk("rd_gnt0", gnt0_s[0], 1);
        chk("rd_mem_en", mem_en_s[0], 1);
        chk("rd_mem_addr", mem_addr_s[0], 16'h0010);
        chk("rd_mem_we", mem_we_s[0], 0);
        tick();
        chk("rd_wait_done0", done0_s[0], 0);
        tick();
        chk("rd_done0", done0_s[0], 1);
        chk("rd_rdata0", rdata0_s[0], 16'hBEEF);
        chk("rd_rdata1", rdata1_s[0], 0);
        tick();
        req0_s[0] = 0;
        chk("rd_idle", busy_s[0], 0);

        // Write to the top address, then read it back on port 0
        set_req(0, 1, 1, 1, 16'hFFFF, 16'h1234);
        tick();
        chk("wr_gnt1", gnt1_s[0], 1);
        chk("wr_mem_we", mem_we_s[0], 1);
        chk("wr_mem_addr", mem_addr_s[0], 16'hFFFF);
        chk("wr_mem_wdata", mem_wdata_s[0], 16'h1234);
        tick();
        chk("wr_mem_en_once", mem_en_s[0], 0);
        tick();
        chk("wr_done1", done1_s[0], 1);
        chk("wr_rdata1", rdata1_s[0], 0);
        tick();
        req1_s[0] = 0;
        set_req(0, 0, 1, 0, 16'hFFFF, 0);
        repeat (3) tick();
        chk("wr_rb_done0", done0_s[0], 1);
        chk("wr_rb_rdata0", rdata0_s[0], 16'h1234);
        tick();
        req0_s[0] = 0;

        // Tie after reset: strict alternation, 3-cycle spacing
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_req(0, 0, 1, 0, 16'h0010, 0);
        set_req(0, 1, 1, 0, 16'h0020, 0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk("tie_busy", busy_s[0], 1);
            if (c % 3 == 1) begin
                chk("tie_gnt0", gnt0_s[0], ((c - 1) / 3) % 2 == 0);
                chk("tie_gnt1", gnt1_s[0], ((c - 1) / 3) % 2 == 1);
            end
            if (c == 12) begin
                req0_s[0] = 0;
                req1_s[0] = 0;
            end
        end
        tick();
        chk("tie_idle", busy_s[0], 0);
        chk("tie_rdata0", rdata0_s[0], 16'hBEEF);
        chk("tie_rdata1", rdata1_s[0], 16'h5A7A);

        // MEM_LAT=3: port 1 read, port 0 arrives mid-flight
        set_req(1, 1, 1, 0, 16'h0010, 0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("l3_busy", busy_s[1], 1);
            chk("l3_done1", done1_s[1], c == 5);
            if (c == 2) set_req(1, 0, 1, 0, 16'h0030, 0);
        end
        chk("l3_rdata1", rdata1_s[1], 16'hBEEF);
        tick();
        req1_s[1] = 0;
        chk("l3_gnt0", gnt0_s[1], 1);
        repeat (4) tick();
        chk("l3_done0", done0_s[1], 1);
        chk("l3_rdata0", rdata0_s[1], 16'h5A6A);
        tick();
        req0_s[1] = 0;
        chk("l3_idle", busy_s[1], 0);

        // Reset during WAIT abandons the transaction
        set_req(1, 0, 1, 0, 16'h0010, 0);
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("ar_mem_en", mem_en_s[1], 0);
        chk("ar_busy", busy_s[1], 0);
        chk("ar_done0", done0_s[1], 0);
        chk("ar_rdata0", rdata0_s[1], 0);
        chk("ar_rdata1", rdata1_s[1], 0);
        tick();
        reset = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) chk("ar_gnt0", gnt0_s[1], 1);
            chk("ar_done0_seq", done0_s[1], c == 5);
        end
        chk("ar_rdata0_after", rdata0_s[1], 16'hBEEF);
        tick();
        req0_s[1] = 0;

        // Concurrent writes then cross reads on both instances
        for (int k = 0; k < 2; k++) begin
            run_pair(k, 1, 16'h0100, 16'hA5A5, 1, 16'h0200, 16'h3C3C);
            run_pair(k, 0, 16'h0200, 16'h0, 0, 16'h0100, 16'h0);
            chk("pair_rdata0", rdata0_s[k], 16'h3C3C);
            chk("pair_rdata1", rdata1_s[k], 16'hA5A5);
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the processor's single-port 16-bit data memory between two requesters: port 0 (instruction-fetch side) and port 1 (load/store side of the multi-cycle state machine). One transaction is in flight at a time, ties are broken round-robin, and each port gets a req/done handshake with a registered read-data return. The block sits between the processor control state machine and the `data` memory array.

## Interface
- `ADDR_W`, 16, memory address width (65536 words).
- `WORD_W`, 16, data word width.
- `MEM_LAT`, 1, cycles from the memory-issue edge to `mem_rdata` valid; legal range 1..7.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  request, level-held until the matching `done`.
- `we0`, `we1`  in  1  1 = write, 0 = read; held with `req`.
- `addr0`, `addr1`  in  ADDR_W  address; held with `req`.
- `wdata0`, `wdata1`  in  WORD_W  write data; held with `req`.
- `gnt0`, `gnt1`  out  1  one-cycle pulse in the issue cycle of that port's transaction.
- `done0`, `done1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  WORD_W  read result; updated only by reads of that port; held between reads.
- `mem_en`  out  1  memory access strobe, high for exactly one cycle per transaction.
- `mem_we`  out  1  memory write enable, qualified by `mem_en`.
- `mem_addr`  out  ADDR_W  registered address.
- `mem_wdata`  out  WORD_W  registered write data.
- `mem_rdata`  in  WORD_W  memory read data.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: evaluate requests; with no request, stay in IDLE.
  - ISSUE: one cycle; drive the memory.
  - WAIT: MEM_LAT cycles; a 3-bit counter loads MEM_LAT-1 on entry and decrements.
  - DONE: one cycle.
- Transitions: IDLE→ISSUE on any request. ISSUE→WAIT. WAIT→DONE when the counter is 0. DONE→ISSUE if an eligible request is present, else DONE→IDLE.
- Grant selection (evaluated in IDLE and DONE):
  - A single request wins.
  - On a tie, the port not equal to `last` wins.
  - `last` is updated to the winner.
  - In DONE, the finishing port's `req` is masked: the requester drops `req` the cycle after `done`.
- On grant, latch `sel`, `we`, `addr` and `wdata` of the winner into the `mem_*` registers, so the memory outputs are valid in ISSUE.
- `mem_en` is high only in ISSUE. `mem_we` = latched `we` and is 0 outside ISSUE.
- Reads: in the last WAIT cycle, capture `mem_rdata` into `rdata[sel]`. Writes leave `rdata` unchanged.
- `gnt[sel]` is high in ISSUE. `done[sel]` is high in DONE, for reads and writes alike.
- Request changes while the other port is in flight are ignored until the next IDLE/DONE evaluation. Requests are level-sensitive and never lost.
- Address arithmetic: none; addresses pass through unmodified. 0xFFFF is a legal address with no wrap logic.

## Timing
- Reset values: state IDLE, `last`=1 (port 0 wins the first tie), counter 0, and every output 0 (`gnt*`, `done*`, `rdata*`, `mem_*`, `busy`).
- Reset asserted mid-transaction:
  - Everything returns to reset values immediately (asynchronous); `mem_en` drops in the same cycle.
  - The abandoned transaction produces no `done`.
  - After release, pending requests are re-arbitrated from IDLE.
- Request latency: `req` first high in IDLE at cycle T:
  - ISSUE (and `gnt`) at T+1.
  - WAIT from T+2 to T+1+MEM_LAT.
  - `done` and valid `rdata` at T+2+MEM_LAT.
- Back-to-back: a DONE→ISSUE transition starts the next transaction with no IDLE bubble. Sustained throughput is one transaction per MEM_LAT+2 cycles.
- Continuous requests on both ports produce strict alternation, so neither port can starve the other.
- `rdata` and `done` are registered outputs; there is no combinational path from any input to any output.

## Test plan
- Read, MEM_LAT=1: memory[0x0010]=0xBEEF; `req0`/`addr0`=0x0010/`we0`=0 at cycle T → `gnt0` and `mem_en`/`mem_addr`=0x0010 at T+1, `done0` with `rdata0`=0xBEEF at T+3, `rdata1` stays 0.
- Write: `req1`, `we1`=1, `addr1`=0xFFFF, `wdata1`=0x1234 → a single `mem_en` cycle with `mem_we`=1, `mem_addr`=0xFFFF, `mem_wdata`=0x1234; then `done1`; `rdata1` unchanged; a later port-0 read of 0xFFFF returns 0x1234.
- Tie after reset, both ports held continuously for 4 transactions → grant order 0,1,0,1; DONE→ISSUE with no IDLE cycle; spacing of 3 cycles at MEM_LAT=1.
- MEM_LAT=3: port-1 read issued at T → `done1` at T+5 and `busy` high for T+1..T+5. Asserting `req0` at T+2 → `gnt0` at T+6.
- `reset` pulled low during WAIT → `mem_en`, `busy`, `done*` and `rdata*` read 0 in the same cycle; no `done` follows. After release with `req0` still held → `gnt0` one cycle after the first post-reset clock edge.
